mem_bus_arbiter: RTL and testbench

- Shares one Avalon-style memory master port (waitrequest, non-pipelined) between the CPU instruction-fetch requester and the data (load/store) requester.
- Sits between the fetch/memory stages and the external memory, including the testbench instruction and data memory models.
- Performs round-robin arbitration, registered bus driving, alignment checking and a waitrequest watchdog.
- Returns per-requester done/error pulses with registered read data.

---
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style (waitrequest, non-pipelined) memory
// port between an instruction-fetch requester and a load/store requester.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic [31:0]       address,
  output logic              read,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata,
  input  logic              waitrequest
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t            state, state_nx;
  logic              last_data;  // 1: most recent grant went to the data requester
  logic              gnt_valid;  // a grant has been latched and is decoded next edge
  logic              gnt_data;
  logic [15:0]       wait_cnt;
  logic [16:0]       wait_inc;
  logic              pick_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              misaligned;
  logic              timed_out;

  always_comb begin
    pick_data  = d_req && (!i_req || !last_data);
    sel_addr   = gnt_data ? d_addr : i_addr;
    misaligned = (sel_addr[1:0] != 2'b00);
    wait_inc   = {1'b0, wait_cnt} + 17'd1;
    timed_out  = (wait_inc == 17'(TIMEOUT));
    state_nx   = state;
    case (state)
      IDLE:    if (gnt_valid) state_nx = misaligned ? DONE : BUS;
      BUS:     if (!waitrequest || timed_out) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_data  <= 1'b1;
      gnt_valid  <= 1'b0;
      gnt_data   <= 1'b0;
      wait_cnt   <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_err      <= 1'b0;
      d_err      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state  <= state_nx;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!gnt_valid) begin
            if (i_req || d_req) begin
              gnt_valid <= 1'b1;
              gnt_data  <= pick_data;
              last_data <= pick_data;
            end
          end else begin
            gnt_valid <= 1'b0;
            if (misaligned) begin
              // Rejected without touching the bus.
              if (gnt_data) begin
                d_done  <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                i_done  <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= '0;
              end
            end else begin
              address    <= 32'(sel_addr) & 32'hFFFF_FFFC;
              read       <= !gnt_data || !d_we;
              write      <= gnt_data && d_we;
              writedata  <= gnt_data ? d_wdata : 32'h0;
              byteenable <= gnt_data ? d_be : 4'b1111;
              wait_cnt   <= '0;
            end
          end
        end
        BUS: begin
          if (!waitrequest || timed_out) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (gnt_data) begin
              d_done  <= 1'b1;
              d_err   <= waitrequest;
              d_rdata <= (!waitrequest && read) ? readdata : 32'h0;
            end else begin
              i_done  <= 1'b1;
              i_err   <= waitrequest;
              i_rdata <= waitrequest ? 32'h0 : readdata;
            end
          end else begin
            wait_cnt <= wait_inc[15:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table of single transactions plus
// hand sequences for ties, the watchdog and asynchronous reset mid-transfer.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;

  logic [31:0] i_rdata, d_rdata, address, writedata;
  logic        i_done, i_err, d_done, d_err, read, write;
  logic [3:0]  byteenable;

  logic [31:0] t_i_rdata, t_d_rdata, t_address, t_writedata;
  logic        t_i_done, t_i_err, t_d_done, t_d_err, t_read, t_write;
  logic [3:0]  t_byteenable;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .TIMEOUT(255)) u0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  mem_bus_arbiter #(.ADDR_W(32), .TIMEOUT(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(t_i_rdata), .i_done(t_i_done), .i_err(t_i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(t_d_rdata), .d_done(t_d_done), .d_err(t_d_err),
    .address(t_address), .read(t_read), .write(t_write), .writedata(t_writedata),
    .byteenable(t_byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] bus_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_strobes;
    int          exp_done_cyc;  // negedges from raising req to seeing done
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Bus exclusivity invariants on the main instance, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("excl_rw", 32'(read && write), 32'h0);
      check("excl_done", 32'(i_done && d_done), 32'h0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   cyc = 0;
    int   strobes = 0;
    logic got = 1'b0;
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    readdata = v.bus_rdata;
    waitrequest = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (read || write) begin
        strobes++;
        check({name, "_addr"}, address, v.addr);
        check({name, "_be"}, 32'(byteenable), v.is_data ? 32'(v.be) : 32'hF);
        check({name, "_read"}, 32'(read), 32'(!(v.is_data && v.we)));
        if (write) check({name, "_wdata"}, writedata, v.wdata);
        waitrequest = (strobes <= v.waits);
      end else begin
        waitrequest = 1'b0;
      end
      if (i_done || d_done) begin
        got = 1'b1;
        check({name, "_cyc"}, 32'(cyc), 32'(v.exp_done_cyc));
        check({name, "_own_done"}, 32'(v.is_data ? d_done : i_done), 32'h1);
        check({name, "_other_done"}, 32'(v.is_data ? i_done : d_done), 32'h0);
        check({name, "_err"}, 32'(v.is_data ? d_err : i_err), 32'(v.exp_err));
        check({name, "_rdata"}, v.is_data ? d_rdata : i_rdata, v.exp_rdata);
        check({name, "_strobes"}, 32'(strobes), 32'(v.exp_strobes));
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    if (!got) check({name, "_done_seen"}, 32'h0, 32'h1);
    waitrequest = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Both requesters raise together: fetch reads 0x80, data writes 0x20.
  task automatic run_tie(input logic exp_data_first, input string name);
    int   cyc = 0;
    logic fi = 1'b0;
    logic fd = 1'b0;
    logic first_data = 1'b0;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_be = 4'b0011;
    readdata = 32'h1111_2222;
    waitrequest = 1'b0;
    while (!(fi && fd) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (write) begin
        check({name, "_w_addr"}, address, 32'h20);
        check({name, "_w_be"}, 32'(byteenable), 32'h3);
        check({name, "_w_data"}, writedata, 32'h1234_5678);
      end
      if (i_done) begin
        if (!fd) first_data = 1'b0;
        fi = 1'b1;
        i_req = 1'b0;
        check({name, "_i_rdata"}, i_rdata, 32'h1111_2222);
        check({name, "_i_err"}, 32'(i_err), 32'h0);
      end
      if (d_done) begin
        if (!fi) first_data = 1'b1;
        fd = 1'b1;
        d_req = 1'b0;
        check({name, "_d_rdata"}, d_rdata, 32'h0);
        check({name, "_d_err"}, 32'(d_err), 32'h0);
      end
    end
    check({name, "_both_done"}, 32'(fi && fd), 32'h1);
    check({name, "_order"}, 32'(first_data), 32'(exp_data_first));
    d_we = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   cyc;
    int   strobes;
    logic got;

    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,         4'hF,    0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,         4'hF,    5, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 6, 8};
    vecs[2] = '{1'b1, 1'b0, 32'h6,   32'h0,         4'hF,    0, 32'h7777_7777, 1'b1, 32'h0,         0, 2};
    vecs[3] = '{1'b1, 1'b1, 32'h20,  32'h1234_5678, 4'b0011, 1, 32'hFFFF_FFFF, 1'b0, 32'h0,         2, 4};
    vecs[4] = '{1'b0, 1'b0, 32'h13,  32'h0,         4'hF,    0, 32'h5555_5555, 1'b1, 32'h0,         0, 2};
    vecs[5] = '{1'b0, 1'b0, 32'h44,  32'h0,         4'hF,    2, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 5};

    repeat (2) @(negedge clk);
    check("rst_read", 32'(read), 32'h0);
    check("rst_write", 32'(write), 32'h0);
    check("rst_i_done", 32'(i_done), 32'h0);
    check("rst_d_done", 32'(d_done), 32'h0);
    check("rst_i_err", 32'(i_err), 32'h0);
    check("rst_d_err", 32'(d_err), 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_byteenable", 32'(byteenable), 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_tie(1'b0, "tie_after_reset");
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    run_tie(1'b1, "tie_after_fetch");

    // Watchdog on the TIMEOUT=3 instance; i_rdata is made nonzero first.
    do_reset();
    run_vec('{1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 0, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1, 3}, "pre_to");
    check("pre_to_t_rdata", t_i_rdata, 32'h5555_AAAA);
    i_req = 1'b1; i_addr = 32'h40;
    waitrequest = 1'b1;
    cyc = 0; strobes = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (t_read) strobes++;
      if (t_i_done) begin
        got = 1'b1;
        i_req = 1'b0;
        check("to_cyc", 32'(cyc), 32'd5);
        check("to_strobes", 32'(strobes), 32'd3);
        check("to_err", 32'(t_i_err), 32'h1);
        check("to_rdata", t_i_rdata, 32'h0);
        check("to_read_low", 32'(t_read), 32'h0);
      end
    end
    if (!got) check("to_done_seen", 32'h0, 32'h1);

    // Main instance is still stalled in its bus cycle; reset it asynchronously.
    @(negedge clk);
    check("mid_read_high", 32'(read), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_read", 32'(read), 32'h0);
    check("async_write", 32'(write), 32'h0);
    check("async_address", address, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 32'(i_done || d_done), 32'h0);
    end
    waitrequest = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_vec('{1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1, 3}, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
